// File: rtl/ecc_sed_pkg.sv
// ecc_sed_pkg
// Shared definitions for the single-error-detect (SED) parity path.
// The encoder and the decoder both use these, so that the parity
// definition exists in one place only.
//   SED_DATA_W / SED_CW_W : default payload and codeword widths
//   sed_state_e           : alarm FSM states
//   sed_parity()          : even-parity bit of a payload (XOR-reduce)
package ecc_sed_pkg;

    localparam int SED_DATA_W = 12;
    localparam int SED_CW_W   = SED_DATA_W + 1;

    typedef enum logic [1:0] {
        SED_OK,
        SED_RUN,
        SED_ALARM
    } sed_state_e;

    // Every payload bit takes part in the XOR. The encoder appends this
    // bit, so that a good codeword XORs to zero.
    function automatic logic sed_parity(input logic [SED_DATA_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/ecc_sed_err_stats.sv
// ecc_sed_err_stats
// Link-health statistics for the SED decoder: a saturating error counter,
// a sticky error flag and a consecutive-error alarm FSM.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   err_pulse    : the word presented this cycle failed parity
//   word_pulse   : a valid word is presented this cycle
//   clr          : synchronous clear; it wins over a same-cycle error
//   err_count    : number of errored words, saturating at all ones
//   err_sticky   : set on any error, held until clr
//   alarm        : ALARM_THRESH consecutive errored words were seen
module ecc_sed_err_stats
    import ecc_sed_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int ALARM_THRESH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             err_pulse,
    input  logic             word_pulse,
    input  logic             clr,
    output logic [CNT_W-1:0] err_count,
    output logic             err_sticky,
    output logic             alarm
);

    localparam logic [7:0] THRESH = 8'(ALARM_THRESH);

    sed_state_e       state_reg;
    logic [7:0]       run_reg;
    logic [CNT_W-1:0] count_reg;
    logic             sticky_reg;
    logic             alarm_reg;

    logic bad_word;
    assign bad_word = word_pulse & err_pulse;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= SED_OK;
            run_reg    <= '0;
            count_reg  <= '0;
            sticky_reg <= 1'b0;
            alarm_reg  <= 1'b0;
        end else if (clr) begin
            // The word arriving with clr is deliberately not counted.
            state_reg  <= SED_OK;
            run_reg    <= '0;
            count_reg  <= '0;
            sticky_reg <= 1'b0;
            alarm_reg  <= 1'b0;
        end else begin
            if (bad_word) begin
                if (count_reg != {CNT_W{1'b1}}) begin
                    count_reg <= count_reg + CNT_W'(1);
                end
                sticky_reg <= 1'b1;
            end

            case (state_reg)
                SED_OK: begin
                    if (bad_word) begin
                        run_reg <= 8'd1;
                        if (THRESH == 8'd1) begin
                            state_reg <= SED_ALARM;
                            alarm_reg <= 1'b1;
                        end else begin
                            state_reg <= SED_RUN;
                        end
                    end
                end
                SED_RUN: begin
                    // Idle cycles leave the run intact. Only a clean valid
                    // word breaks it.
                    if (word_pulse) begin
                        if (err_pulse) begin
                            run_reg <= run_reg + 8'd1;
                            if (run_reg + 8'd1 == THRESH) begin
                                state_reg <= SED_ALARM;
                                alarm_reg <= 1'b1;
                            end
                        end else begin
                            state_reg <= SED_OK;
                            run_reg   <= '0;
                        end
                    end
                end
                SED_ALARM: begin
                    // The alarm latches. Only clr or reset releases it.
                    alarm_reg <= 1'b1;
                end
                default: begin
                    state_reg <= SED_OK;
                    run_reg   <= '0;
                    alarm_reg <= 1'b0;
                end
            endcase
        end
    end

    assign err_count  = count_reg;
    assign err_sticky = sticky_reg;
    assign alarm      = alarm_reg;

endmodule

// File: rtl/ecc_sed_decoder.sv
// ecc_sed_decoder
// Receive side of the SED parity path. It checks the even parity of each
// codeword and forwards the data uncorrected, with a per-word error flag,
// one cycle later. It also keeps link-health statistics.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   enc_valid     : codeword valid this cycle
//   enc_codeword  : {parity, data}, DATA_W+1 bits
//   clr_stats     : synchronous clear of the counter, sticky flag and alarm
//   data_valid    : registered enc_valid
//   data          : registered data field; holds while idle
//   parity_err    : the word on data failed parity; holds while idle
//   err_count     : saturating count of errored words
//   err_sticky    : set on any error until clr_stats
//   alarm         : consecutive-error alarm
module ecc_sed_decoder
    import ecc_sed_pkg::*;
#(
    parameter int DATA_W       = 12,
    parameter int CNT_W        = 16,
    parameter int ALARM_THRESH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enc_valid,
    input  logic [DATA_W:0]   enc_codeword,
    input  logic              clr_stats,
    output logic              data_valid,
    output logic [DATA_W-1:0] data,
    output logic              parity_err,
    output logic [CNT_W-1:0]  err_count,
    output logic              err_sticky,
    output logic              alarm
);

    logic syndrome;

    // At the default width, use the shared package function so that the
    // decoder and the encoder cannot drift apart. Other widths use a plain
    // XOR-reduce, which is the same definition.
    generate
        if (DATA_W == SED_DATA_W) begin : g_pkg_parity
            assign syndrome = sed_parity(enc_codeword[DATA_W-1:0]) ^ enc_codeword[DATA_W];
        end else begin : g_generic_parity
            assign syndrome = ^enc_codeword;
        end
    endgenerate

    logic              data_valid_reg;
    logic [DATA_W-1:0] data_reg;
    logic              parity_err_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_valid_reg <= 1'b0;
            data_reg       <= '0;
            parity_err_reg <= 1'b0;
        end else begin
            data_valid_reg <= enc_valid;
            if (enc_valid) begin
                data_reg       <= enc_codeword[DATA_W-1:0];
                parity_err_reg <= syndrome;
            end
        end
    end

    // The statistics registers update on the same edge as parity_err, so
    // they already include the word that data_valid shows.
    ecc_sed_err_stats #(
        .CNT_W       (CNT_W),
        .ALARM_THRESH(ALARM_THRESH)
    ) u_stats (
        .clk        (clk),
        .rst        (rst),
        .err_pulse  (enc_valid & syndrome),
        .word_pulse (enc_valid),
        .clr        (clr_stats),
        .err_count  (err_count),
        .err_sticky (err_sticky),
        .alarm      (alarm)
    );

    assign data_valid = data_valid_reg;
    assign data       = data_reg;
    assign parity_err = parity_err_reg;

endmodule

// File: tb/tb_ecc_sed_decoder.sv
// tb_ecc_sed_decoder
// Directed, table-driven bench for ecc_sed_decoder. A second instance with
// CNT_W=4 shares the same stimulus and covers counter saturation.
// Note: 12'hABC has popcount 7 (odd). Its good even-parity codeword is
// therefore 13'h1ABC, and 13'h0ABC is an errored word.
module tb_ecc_sed_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        enc_valid;
    logic [12:0] enc_codeword;
    logic        clr_stats;

    logic        data_valid;
    logic [11:0] data;
    logic        parity_err;
    logic [15:0] err_count;
    logic        err_sticky;
    logic        alarm;

    logic        s_data_valid;
    logic [11:0] s_data;
    logic        s_parity_err;
    logic [3:0]  s_err_count;
    logic        s_err_sticky;
    logic        s_alarm;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ecc_sed_decoder #(.DATA_W(12), .CNT_W(16), .ALARM_THRESH(4)) u_dut (
        .clk(clk), .rst(rst), .enc_valid(enc_valid), .enc_codeword(enc_codeword),
        .clr_stats(clr_stats), .data_valid(data_valid), .data(data),
        .parity_err(parity_err), .err_count(err_count), .err_sticky(err_sticky),
        .alarm(alarm)
    );

    ecc_sed_decoder #(.DATA_W(12), .CNT_W(4), .ALARM_THRESH(4)) u_sat (
        .clk(clk), .rst(rst), .enc_valid(enc_valid), .enc_codeword(enc_codeword),
        .clr_stats(clr_stats), .data_valid(s_data_valid), .data(s_data),
        .parity_err(s_parity_err), .err_count(s_err_count), .err_sticky(s_err_sticky),
        .alarm(s_alarm)
    );

    typedef struct packed {
        logic        v;
        logic [12:0] cw;
        logic        clr;
        logic        dv;
        logic [11:0] data;
        logic        perr;
        logic [15:0] cnt;
        logic        st;
        logic        al;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [12:0] cw, input logic clr,
                       input logic dv, input logic [11:0] d, input logic perr,
                       input logic [15:0] cnt, input logic st, input logic al);
        vec_t t;
        t.v = v; t.cw = cw; t.clr = clr; t.dv = dv; t.data = d; t.perr = perr;
        t.cnt = cnt; t.st = st; t.al = al;
        vecs.push_back(t);
    endtask

    // Drive on the falling edge, then sample 1 time unit after the rising edge.
    task automatic step(input logic v, input logic [12:0] cw, input logic clr);
        @(negedge clk);
        enc_valid    = v;
        enc_codeword = cw;
        clr_stats    = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic dv, input logic [11:0] d,
                           input logic perr, input logic [15:0] cnt,
                           input logic st, input logic al);
        chk({tag, ".data_valid"}, 32'(data_valid), 32'(dv));
        chk({tag, ".data"},       32'(data),       32'(d));
        chk({tag, ".parity_err"}, 32'(parity_err), 32'(perr));
        chk({tag, ".err_count"},  32'(err_count),  32'(cnt));
        chk({tag, ".err_sticky"}, 32'(err_sticky), 32'(st));
        chk({tag, ".alarm"},      32'(alarm),      32'(al));
    endtask

    initial begin
        logic [12:0] cw;
        rst = 1'b1; enc_valid = 1'b0; enc_codeword = '0; clr_stats = 1'b0;

        // ---- Reset state ----
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 1'b0, 12'h000, 1'b0, 16'd0, 1'b0, 1'b0);
        @(negedge clk); rst = 1'b0;

        // One errored word so that reset has something to clear.
        step(1'b1, 13'h0ABC, 1'b0);
        chk_all("pre_rst", 1'b1, 12'hABC, 1'b1, 16'd1, 1'b1, 1'b0);
        $display("pre-reset word 0ABC: dv=%0b data=%h perr=%0b cnt=%0d", data_valid, data, parity_err, err_count);

        // Assert reset mid-cycle while a word is in flight.
        @(negedge clk);
        enc_valid = 1'b1; enc_codeword = 13'h1ABC;
        #2 rst = 1'b1;
        #1;
        chk_all("async_rst", 1'b0, 12'h000, 1'b0, 16'd0, 1'b0, 1'b0);
        @(negedge clk); rst = 1'b0; enc_valid = 1'b0;
        @(posedge clk); #1;
        chk_all("rst_lost_word", 1'b0, 12'h000, 1'b0, 16'd0, 1'b0, 1'b0);

        // ---- Vector table ----
        add(1'b1, 13'h1ABC, 1'b0, 1'b1, 12'hABC, 1'b0, 16'd0, 1'b0, 1'b0); // clean
        add(1'b1, 13'h0000, 1'b0, 1'b1, 12'h000, 1'b0, 16'd0, 1'b0, 1'b0); // clean zero
        add(1'b1, 13'h0ABC, 1'b0, 1'b1, 12'hABC, 1'b1, 16'd1, 1'b1, 1'b0); // run=1
        // Single-bit flips of the good word at bits 0..12; alarm on the 4th errored word in a row.
        for (int i = 0; i < 13; i++) begin
            cw = 13'h1ABC ^ (13'h1 << i);
            add(1'b1, cw, 1'b0, 1'b1, cw[11:0], 1'b1, 16'(2 + i), 1'b1, (i >= 2));
        end
        // clr wins over a same-cycle error; the word is still flagged.
        add(1'b1, 13'h0ABC, 1'b1, 1'b1, 12'hABC, 1'b1, 16'd0, 1'b0, 1'b0);
        // Alarm run: err, err, clean, then 4 errors with idles in between.
        add(1'b1, 13'h0ABC, 1'b0, 1'b1, 12'hABC, 1'b1, 16'd1, 1'b1, 1'b0);
        add(1'b1, 13'h1ABD, 1'b0, 1'b1, 12'hABD, 1'b1, 16'd2, 1'b1, 1'b0);
        add(1'b1, 13'h1ABC, 1'b0, 1'b1, 12'hABC, 1'b0, 16'd2, 1'b1, 1'b0);
        add(1'b1, 13'h0ABC, 1'b0, 1'b1, 12'hABC, 1'b1, 16'd3, 1'b1, 1'b0);
        add(1'b0, 13'h1FFF, 1'b0, 1'b0, 12'hABC, 1'b1, 16'd3, 1'b1, 1'b0); // idle
        add(1'b1, 13'h1ABD, 1'b0, 1'b1, 12'hABD, 1'b1, 16'd4, 1'b1, 1'b0);
        add(1'b0, 13'h0000, 1'b0, 1'b0, 12'hABD, 1'b1, 16'd4, 1'b1, 1'b0); // idle
        add(1'b1, 13'h0ABC, 1'b0, 1'b1, 12'hABC, 1'b1, 16'd5, 1'b1, 1'b0);
        add(1'b1, 13'h0001, 1'b0, 1'b1, 12'h001, 1'b1, 16'd6, 1'b1, 1'b1); // 4th errored word
        add(1'b1, 13'h1ABC, 1'b0, 1'b1, 12'hABC, 1'b0, 16'd6, 1'b1, 1'b1); // clean keeps alarm
        add(1'b0, 13'h0FFF, 1'b0, 1'b0, 12'hABC, 1'b0, 16'd6, 1'b1, 1'b1); // idle hold
        add(1'b0, 13'h0FFF, 1'b1, 1'b0, 12'hABC, 1'b0, 16'd0, 1'b0, 1'b0); // clr only

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].v, vecs[i].cw, vecs[i].clr);
            chk_all($sformatf("vec%0d", i), vecs[i].dv, vecs[i].data, vecs[i].perr,
                    vecs[i].cnt, vecs[i].st, vecs[i].al);
            $display("vec %0d: v=%0b cw=%h clr=%0b -> dv=%0b data=%h perr=%0b cnt=%0d st=%0b al=%0b",
                     i, vecs[i].v, vecs[i].cw, vecs[i].clr, data_valid, data, parity_err,
                     err_count, err_sticky, alarm);
        end

        // ---- Saturation (CNT_W=4 instance) ----
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 13'h0ABC, 1'b0);
            chk($sformatf("sat%0d.main_cnt", i), 32'(err_count), 32'(i + 1));
            chk($sformatf("sat%0d.sat_cnt", i), 32'(s_err_count), 32'((i + 1 > 15) ? 15 : i + 1));
            $display("sat %0d: main cnt=%0d sat cnt=%0d", i, err_count, s_err_count);
        end
        chk("sat.sticky", 32'(s_err_sticky), 32'd1);
        chk("sat.alarm", 32'(s_alarm), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
